// File: rtl/ysyx_23060208_ifetch_master_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060208_ifetch_master_pkg
// Description : Shared types and constants for the IFU fetch master.
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_23060208_ifetch_master_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2,
        S_HOLD = 2'd3
    } ifm_state_e;

    localparam logic [1:0]  RESP_OKAY        = 2'b00;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage : ysyx_23060208_ifetch_master_pkg
`default_nettype wire

// File: rtl/ysyx_23060208_ifetch_master.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060208_ifetch_master
// Description : Single-outstanding instruction fetch initiator with a
//               one-entry instruction buffer and wrong-path discard.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_23060208_ifetch_master
    import ysyx_23060208_ifetch_master_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst,

    output logic [DATA_WIDTH-1:0] ifm_araddr,
    output logic                  ifm_arvalid,
    input  logic                  ifm_arready,
    input  logic [1:0]            ifm_rresp,
    input  logic                  ifm_rvalid,
    input  logic [DATA_WIDTH-1:0] ifm_rdata,
    output logic                  ifm_rready,

    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,

    output logic                  ifu_to_idu_valid,
    output logic [DATA_WIDTH-1:0] ifu_to_idu_inst,
    output logic [DATA_WIDTH-1:0] ifu_to_idu_pc,
    output logic                  ifu_to_idu_err,
    input  logic                  idu_allowin
);

    ifm_state_e            state_q,   state_d;
    logic [DATA_WIDTH-1:0] pc_q,      pc_d;
    logic [DATA_WIDTH-1:0] inst_q,    inst_d;
    logic                  err_q,     err_d;
    logic                  discard_q, discard_d;
    logic [DATA_WIDTH-1:0] pend_pc_q, pend_pc_d;

    logic w_ar_hs;
    logic w_r_hs;

    assign ifm_arvalid      = (state_q == S_AR);
    assign ifm_rready       = (state_q == S_R);
    assign ifm_araddr       = pc_q;
    assign ifu_to_idu_valid = (state_q == S_HOLD) & ~redirect_valid;
    assign ifu_to_idu_pc    = pc_q;
    assign ifu_to_idu_inst  = inst_q;
    assign ifu_to_idu_err   = err_q;

    assign w_ar_hs = ifm_arvalid & ifm_arready;
    assign w_r_hs  = ifm_rvalid & ifm_rready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            inst_q    <= '0;
            err_q     <= 1'b0;
            discard_q <= 1'b0;
            pend_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            err_q     <= err_d;
            discard_q <= discard_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        err_d     = err_q;
        discard_d = discard_q;
        pend_pc_d = pend_pc_q;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_AR;
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end
            end

            // The address must not move while arvalid is up, so a redirect
            // here only records its target and marks the fetch wrong-path.
            S_AR: begin
                if (redirect_valid) begin
                    discard_d = 1'b1;
                    pend_pc_d = redirect_pc;
                end
                if (w_ar_hs) begin
                    state_d = S_R;
                end
            end

            S_R: begin
                if (w_r_hs) begin
                    if (discard_q || redirect_valid) begin
                        pc_d      = redirect_valid ? redirect_pc : pend_pc_q;
                        discard_d = 1'b0;
                        state_d   = S_AR;
                    end else begin
                        inst_d  = ifm_rdata;
                        err_d   = (ifm_rresp != RESP_OKAY);
                        state_d = S_HOLD;
                    end
                end else if (redirect_valid) begin
                    discard_d = 1'b1;
                    pend_pc_d = redirect_pc;
                end
            end

            S_HOLD: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = S_AR;
                end else if (idu_allowin) begin
                    pc_d    = pc_q + DATA_WIDTH'(4);
                    state_d = S_AR;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule : ysyx_23060208_ifetch_master
`default_nettype wire

// File: doc/ysyx_23060208_ifetch_master.md
# ysyx_23060208_ifetch_master

Instruction-fetch read initiator for the IFU. It drives the AXI-lite-style AR/R channels toward the instruction SRAM responder and keeps the fetch PC. It buffers one returned instruction and presents it with its PC to the IDU. It also accepts PC redirects from the backend and discards any wrong-path fetch that is still in flight.

## Interface
Parameters:
- DATA_WIDTH, 32, width of address, data and PC.
- RESET_PC, 32'h8000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- ifm_araddr  out  DATA_WIDTH  fetch address.
- ifm_arvalid  out  1  read request valid.
- ifm_arready  in  1  responder accepts the request.
- ifm_rresp  in  2  response code; 2'b00 means OKAY.
- ifm_rvalid  in  1  read data valid.
- ifm_rdata  in  DATA_WIDTH  instruction word.
- ifm_rready  out  1  master accepts the data.
- redirect_valid  in  1  backend redirect request.
- redirect_pc  in  DATA_WIDTH  redirect target.
- ifu_to_idu_valid  out  1  instruction available for the IDU.
- ifu_to_idu_inst  out  DATA_WIDTH  buffered instruction.
- ifu_to_idu_pc  out  DATA_WIDTH  PC of the buffered instruction.
- ifu_to_idu_err  out  1  buffered response was not OKAY.
- idu_allowin  in  1  IDU accepts this cycle.

## Operation
- FSM states:
  - IDLE: only after reset.
  - AR: request outstanding.
  - R: waiting for data.
  - HOLD: instruction buffered.
- Registers:
  - pc: fetch PC.
  - inst_r, err_r: buffered instruction and error flag.
  - discard: the in-flight fetch is wrong-path.
  - pend_pc: pending redirect target.
- Combinational outputs:
  - ifm_arvalid = (state==AR).
  - ifm_rready = (state==R).
  - ifm_araddr = pc.
  - ifu_to_idu_valid = (state==HOLD) & ~redirect_valid.
  - ifu_to_idu_pc = pc.
- Transitions:
  - IDLE → AR unconditionally. If redirect_valid, pc ← redirect_pc.
  - AR:
    - pc is held stable until arvalid&arready; the address never changes while arvalid is high.
    - On handshake → R.
    - A redirect in AR, with or without handshake in the same cycle, sets discard=1 and pend_pc ← redirect_pc.
  - R, on rvalid&rready:
    - discard=1 (or redirect_valid this cycle): drop the data. pc ← (redirect_valid ? redirect_pc : pend_pc), clear discard, → AR.
    - Otherwise: inst_r ← rdata, err_r ← (rresp!=2'b00), → HOLD.
    - A redirect in R without handshake sets discard=1 and pend_pc ← redirect_pc.
  - HOLD:
    - redirect_valid has priority: the buffered instruction is dropped and not delivered. pc ← redirect_pc, → AR.
    - Else if idu_allowin: handoff. pc ← pc+4, → AR.
    - Else stay in HOLD; outputs stay stable.
- When several redirects arrive while discard=1, the latest redirect wins.
- pc+4 wraps modulo 2^DATA_WIDTH, so 32'hFFFF_FFFC → 32'h0000_0000.
- err_r does not stall the FSM; the IDU handles the exception.

## Timing
- Reset values:
  - state=IDLE, pc=RESET_PC, discard=0, pend_pc=0, inst_r=0, err_r=0.
  - ifm_arvalid=0, ifm_rready=0, ifu_to_idu_valid=0.
  - ifm_araddr=RESET_PC, ifu_to_idu_pc=RESET_PC, ifu_to_idu_inst=0, ifu_to_idu_err=0.
- First arvalid is asserted in the 2nd cycle after rst deasserts (IDLE takes one cycle).
- arvalid is never dropped before arready. The master tolerates arready being low for any number of cycles, including after reset.
- Latency: rvalid handshake at cycle N gives ifu_to_idu_valid at N+1.
- Handoff at cycle M gives arvalid for pc+4 at M+1.
- With a zero-wait responder, minimum spacing is 3 cycles per instruction.
- Only one transaction is outstanding at a time. No new AR is issued until the R handshake completes.
- Reset mid-transaction (any state) returns to reset values at the next edge. Responder-side state is reset by the same rst.

## Structure
- Shared package holds:
  - state encoding constants (IDLE/AR/R/HOLD);
  - RESP_OKAY = 2'b00;
  - default RESET_PC.
- Single module, no sub-module. The FSM and datapath are too tightly coupled to split.

## Test plan
- Reset, then responder with arready=1 and 1-cycle rdata=32'h0000_0413 → araddr 32'h8000_0000 in the 2nd cycle after reset. IDU sees valid, inst 32'h0000_0413, pc 32'h8000_0000; next request is to 32'h8000_0004.
- IDU holds idu_allowin=0 for 5 cycles in HOLD → valid/inst/pc stay stable and no arvalid is issued. On allowin=1, exactly one handoff occurs.
- arready held low 4 cycles while redirect_valid pulses with redirect_pc=32'h8000_0100 → araddr stays 32'h8000_0000 until the handshake. That response is discarded, the next araddr is 32'h8000_0100, and the IDU never sees the 32'h8000_0000 data.
- In HOLD, redirect_valid=1 and idu_allowin=1 in the same cycle → ifu_to_idu_valid=0 that cycle and the next fetch is to redirect_pc.
- Responder returns rresp=2'b10 → ifu_to_idu_err=1 with that instruction. The next fetch proceeds normally with err=0 on an OKAY response.
- Redirect to 32'hFFFF_FFFC, then a handoff → next araddr is 32'h0000_0000. An rst pulse asserted while in R returns all outputs to reset values.
